imem_loader: RTL and testbench

Boot-time program loader that writes the instruction memory read by the single-cycle core's PC/instruction-fetch path. It accepts a byte stream with a length header and assembles little-endian 32-bit instructions. It writes each instruction to consecutive word addresses and holds the core in reset until the load completes. It sits between the external byte source (UART/testbench) and the instruction memory write port.

---
 rtl/imem_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_imem_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that assembles little-endian 32-bit words
// from a length-prefixed byte stream and writes them to instruction memory.
//
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   start           - one-cycle pulse, begins a load when not busy
//   byte_valid/data - byte source, transfers when byte_valid & byte_ready
//   byte_ready      - loader can accept a byte this cycle
//   wr_en/addr/data - instruction-memory write port, one strobe per word
//   core_reset      - holds the core in reset until a clean load finishes
//   busy, done      - load in progress / last load finished
//   overflow        - header exceeded capacity, excess words discarded
//   csum_err        - trailing checksum byte mismatched
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to expect one trailing
// checksum byte (8-bit sum of all data bytes) after the payload.

module imem_loader #(
    parameter int PC_W  = 8,
    parameter int INS_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             wr_en,
    output logic [PC_W-1:0]  wr_addr,
    output logic [INS_W-1:0] wr_data,
    output logic             core_reset,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             csum_err
);

    // Capacity in words; word indices at or above it are dropped.
    localparam logic [31:0] CAP = 32'(1) << (PC_W - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       n_q, n_d;
    logic [7:0]       widx_q, widx_d;
    logic [1:0]       bidx_q, bidx_d;
    logic [INS_W-1:0] word_q, word_d;
    logic             ovf_q, ovf_d;
    logic             accept;
    logic             in_range;
    logic             last_word;
    state_t           fin_state;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       sum_q, sum_d;
    logic             cerr_q, cerr_d;
    assign fin_state = S_CSUM;
`else
    assign fin_state = S_DONE;
`endif

    // Handshake side: ready purely from state so sources see a stable level.
    always_comb begin
        byte_ready = 1'b0;
        unique case (state_q)
            S_HDR:   byte_ready = 1'b1;
            S_DATA:  byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM:  byte_ready = 1'b1;
`endif
            default: byte_ready = 1'b0;
        endcase
    end

    assign accept    = byte_valid & byte_ready;
    assign in_range  = {24'd0, widx_q} < CAP;
    assign last_word = ({1'b0, widx_q} + 9'd1) == {1'b0, n_q};

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;
        word_d  = word_q;
        ovf_d   = ovf_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
        cerr_d  = cerr_q;
`endif
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_HDR;
                    ovf_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    cerr_d  = 1'b0;
`endif
                end
            end

            S_HDR: begin
                if (accept) begin
                    n_d    = byte_data;
                    widx_d = '0;
                    bidx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d  = '0;
`endif
                    if (byte_data == 8'd0) begin
                        state_d = fin_state;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (accept) begin
                    // Little-endian: first byte of a word lands in [7:0].
                    unique case (bidx_q)
                        2'd0: word_d[7:0]   = byte_data;
                        2'd1: word_d[15:8]  = byte_data;
                        2'd2: word_d[23:16] = byte_data;
                        2'd3: word_d[31:24] = byte_data;
                        default: ;
                    endcase
                    bidx_d = bidx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d  = sum_q + byte_data;
`endif
                    if (bidx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                wr_addr = PC_W'({widx_q, 2'b00});
                wr_data = word_q;
                // Words past capacity are consumed but never written.
                if (in_range) begin
                    wr_en = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
                widx_d = widx_q + 8'd1;
                if (last_word) begin
                    state_d = fin_state;
                end else begin
                    state_d = S_DATA;
                end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    cerr_d  = (byte_data != sum_q);
                    state_d = S_DONE;
                end
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            widx_q  <= '0;
            bidx_q  <= '0;
            word_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            widx_q  <= widx_d;
            bidx_q  <= bidx_d;
            word_q  <= word_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q  <= '0;
            cerr_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cerr_q <= cerr_d;
        end
    end
    assign csum_err = cerr_q;
`else
    assign csum_err = 1'b0;
`endif

    assign done     = (state_q == S_DONE);
    assign overflow = ovf_q;

    always_comb begin
        busy = 1'b0;
        unique case (state_q)
            S_HDR:   busy = 1'b1;
            S_DATA:  busy = 1'b1;
            S_WRITE: busy = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM:  busy = 1'b1;
`endif
            default: busy = 1'b0;
        endcase
    end

    // The core is released only by a load that ended without a checksum error.
    assign core_reset = ~(done & ~csum_err);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives two loader instances (64-word and 4-word capacity)
// from one byte stream and compares against a word-list reference model.

module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    localparam int CAP_A = 64;
    localparam int CAP_B = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;

    logic        a_ready, a_wr_en, a_core_reset, a_busy, a_done, a_ovf, a_cerr;
    logic [7:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic        b_ready, b_wr_en, b_core_reset, b_busy, b_done, b_ovf, b_cerr;
    logic [3:0]  b_wr_addr;
    logic [31:0] b_wr_data;

    int tests = 0;
    int fails = 0;

    logic [31:0] a_addr_q[$], a_data_q[$], b_addr_q[$], b_data_q[$];
    logic        a_prev = 1'b0;
    logic        b_prev = 1'b0;

    always #5 clk = ~clk;

    imem_loader #(.PC_W(8), .INS_W(32)) u_a (
        .clk(clk), .reset(reset), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(a_ready), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
        .wr_data(a_wr_data), .core_reset(a_core_reset), .busy(a_busy),
        .done(a_done), .overflow(a_ovf), .csum_err(a_cerr)
    );

    imem_loader #(.PC_W(4), .INS_W(32)) u_b (
        .clk(clk), .reset(reset), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(b_ready), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .core_reset(b_core_reset), .busy(b_busy),
        .done(b_done), .overflow(b_ovf), .csum_err(b_cerr)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: collect writes, each strobe one cycle, never with ready.
    always @(negedge clk) begin
        if (a_wr_en) begin
            check("a_wr_ready_low", a_ready, 0);
            check("a_wr_single", a_prev, 0);
            a_addr_q.push_back(32'(a_wr_addr));
            a_data_q.push_back(a_wr_data);
        end
        if (b_wr_en) begin
            check("b_wr_ready_low", b_ready, 0);
            check("b_wr_single", b_prev, 0);
            b_addr_q.push_back(32'(b_wr_addr));
            b_data_q.push_back(b_wr_data);
        end
        a_prev <= a_wr_en;
        b_prev <= b_wr_en;
    end

    task automatic check_reset_outs(input string tag);
        check({tag, "_a_ready"}, a_ready, 0);
        check({tag, "_a_wr_en"}, a_wr_en, 0);
        check({tag, "_a_wr_addr"}, a_wr_addr, 0);
        check({tag, "_a_wr_data"}, a_wr_data, 0);
        check({tag, "_a_core_reset"}, a_core_reset, 1);
        check({tag, "_a_busy"}, a_busy, 0);
        check({tag, "_a_done"}, a_done, 0);
        check({tag, "_a_ovf"}, a_ovf, 0);
        check({tag, "_a_cerr"}, a_cerr, 0);
        check({tag, "_b_ready"}, b_ready, 0);
        check({tag, "_b_core_reset"}, b_core_reset, 1);
        check({tag, "_b_busy"}, b_busy, 0);
        check({tag, "_b_ovf"}, b_ovf, 0);
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                byte_valid = 1'b0;
                @(negedge clk);
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (!a_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("ready_timeout", t, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic rand_payload(input int n, output logic [7:0] p[$]);
        p = {};
        for (int i = 0; i < 4 * n; i++) p.push_back(8'($urandom));
    endtask

    task automatic run_load(input string tag, input logic [7:0] payload[$],
                            input int n, input bit gaps, input bit poke,
                            input logic [7:0] bad);
        logic [31:0] ea_addr[$], ea_data[$], eb_addr[$], eb_data[$];
        logic [31:0] w;
        logic [7:0]  sum = 8'd0;
        int          sent = 0;
        bit          exp_cerr;

        for (int i = 0; i < n; i++) begin
            w = {payload[4*i+3], payload[4*i+2],
                 payload[4*i+1], payload[4*i]};
            if (i < CAP_A) begin
                ea_addr.push_back(32'(4 * i));
                ea_data.push_back(w);
            end
            if (i < CAP_B) begin
                eb_addr.push_back(32'(4 * i));
                eb_data.push_back(w);
            end
        end
        foreach (payload[k]) sum = sum + payload[k];
        exp_cerr = CK && (bad != 8'd0);

        a_addr_q = {}; a_data_q = {}; b_addr_q = {}; b_data_q = {};

        pulse_start();
        check({tag, "_hdr_ready"}, a_ready, 1);
        check({tag, "_hdr_busy"}, a_busy, 1);
        check({tag, "_hdr_core_reset"}, a_core_reset, 1);

        send_byte(8'(n), gaps);
        sent++;
        for (int i = 0; i < payload.size(); i++) begin
            if (poke && i == 2) start = 1'b1;
            send_byte(payload[i], gaps);
            sent++;
        end
        if (CK) begin
            if (n > 0) begin
                check({tag, "_wr_cycle"}, a_ready, 0);
                @(negedge clk);
            end
            send_byte(sum ^ bad, gaps);
            sent++;
        end else if (n > 0) begin
            check({tag, "_pre_done"}, a_done, 0);
            check({tag, "_wr_cycle_busy"}, a_busy, 1);
            @(negedge clk);
        end

        check({tag, "_bytes"}, sent, 1 + 4 * n + (CK ? 1 : 0));
        check({tag, "_a_done"}, a_done, 1);
        check({tag, "_a_busy"}, a_busy, 0);
        check({tag, "_a_core_reset"}, a_core_reset, exp_cerr);
        check({tag, "_a_cerr"}, a_cerr, exp_cerr);
        check({tag, "_a_ovf"}, a_ovf, n > CAP_A);
        check({tag, "_b_done"}, b_done, 1);
        check({tag, "_b_ovf"}, b_ovf, n > CAP_B);

        check({tag, "_a_nwr"}, a_addr_q.size(), ea_addr.size());
        check({tag, "_b_nwr"}, b_addr_q.size(), eb_addr.size());
        for (int i = 0; i < ea_addr.size() && i < a_addr_q.size(); i++) begin
            check({tag, "_a_addr"}, a_addr_q[i], ea_addr[i]);
            check({tag, "_a_data"}, a_data_q[i], ea_data[i]);
        end
        for (int i = 0; i < eb_addr.size() && i < b_addr_q.size(); i++) begin
            check({tag, "_b_addr"}, b_addr_q[i], eb_addr[i]);
            check({tag, "_b_data"}, b_data_q[i], eb_data[i]);
        end
    endtask

    initial begin
        logic [7:0] p[$];
        logic [7:0] fixed[$];
        int n;

        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        repeat (2) @(negedge clk);
        check_reset_outs("rst");
        reset = 1'b0;
        @(negedge clk);
        check_reset_outs("idle");

        fixed = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load("dir", fixed, 2, 1'b0, 1'b0, 8'd0);
        run_load("gaps", fixed, 2, 1'b1, 1'b1, 8'd0);

        p = {};
        run_load("n0", p, 0, 1'b0, 1'b0, 8'd0);

        rand_payload(6, p);
        run_load("n6", p, 6, 1'b0, 1'b0, 8'd0);

        // Abort mid-load after the 2nd byte of word 1.
        rand_payload(3, p);
        pulse_start();
        send_byte(8'd3, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(p[i], 1'b0);
        reset = 1'b1;
        #1;
        check_reset_outs("abort");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outs("abort_idle");
        run_load("after_abort", p, 3, 1'b1, 1'b0, 8'd0);

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 9);
            rand_payload(n, p);
            run_load("rand", p, n, 1'($urandom_range(0, 1)), 1'b0, 8'd0);
        end

        rand_payload(66, p);
        run_load("n66", p, 66, 1'b0, 1'b0, 8'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        fixed = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load("ck_ok", fixed, 1, 1'b0, 1'b0, 8'd0);
        run_load("ck_bad", fixed, 1, 1'b0, 1'b0, 8'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
